// File: rtl/slow_multiplication_stage.sv
// One shift-and-add step: moves the multiplicand left, the multiplier right,
// and adds the multiplicand into the running sum when the multiplier LSB is set.
module slow_multiplication_stage #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] in_1_i,
    input  logic [WIDTH-1:0]   in_2_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [2*WIDTH-1:0] in_1_o,
    output logic [WIDTH-1:0]   in_2_o,
    output logic [2*WIDTH-1:0] acc_o
);

    assign in_1_o = in_1_i << 1;
    assign in_2_o = in_2_i >> 1;
    assign acc_o  = acc_i + (in_2_i[0] ? in_1_i : '0);

endmodule

// File: rtl/slow_multiplication.sv
// Pipelined unsigned shift-and-add multiplier: WIDTH stages, one product per
// clock, product appears on out WIDTH enabled clocks after operands are sampled.
module slow_multiplication #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [WIDTH-1:0]   in_1,
    input  logic [WIDTH-1:0]   in_2,
    output logic [2*WIDTH-1:0] out
);

    localparam int PW = 2 * WIDTH;
    localparam int NS = WIDTH - 1;

    logic [PW-1:0]    in_1_shift   [NS];
    logic [WIDTH-1:0] in_2_shift   [NS];
    logic [PW-1:0]    tmp_result   [NS];
    logic [PW-1:0]    in_1_shift_d [NS];
    logic [WIDTH-1:0] in_2_shift_d [NS];
    logic [PW-1:0]    tmp_result_d [NS];
    logic [PW-1:0]    out_d;

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // Stage 0 takes the raw operands with an empty accumulator.
                slow_multiplication_stage #(.WIDTH(WIDTH)) u_stage (
                    .in_1_i ({{WIDTH{1'b0}}, in_1}),
                    .in_2_i (in_2),
                    .acc_i  ('0),
                    .in_1_o (in_1_shift_d[gi]),
                    .in_2_o (in_2_shift_d[gi]),
                    .acc_o  (tmp_result_d[gi])
                );
            end else begin : g_mid
                slow_multiplication_stage #(.WIDTH(WIDTH)) u_stage (
                    .in_1_i (in_1_shift[gi-1]),
                    .in_2_i (in_2_shift[gi-1]),
                    .acc_i  (tmp_result[gi-1]),
                    .in_1_o (in_1_shift_d[gi]),
                    .in_2_o (in_2_shift_d[gi]),
                    .acc_o  (tmp_result_d[gi])
                );
            end
        end
    endgenerate

    // The last step needs only the sum, so it is folded into the output register.
    assign out_d = tmp_result[NS-1] + (in_2_shift[NS-1][0] ? in_1_shift[NS-1] : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                in_1_shift[i] <= '0;
                in_2_shift[i] <= '0;
                tmp_result[i] <= '0;
            end
            out <= '0;
        end else if (enable) begin
            for (int i = 0; i < NS; i++) begin
                in_1_shift[i] <= in_1_shift_d[i];
                in_2_shift[i] <= in_2_shift_d[i];
                tmp_result[i] <= tmp_result_d[i];
            end
            out <= out_d;
        end
    end

endmodule

// File: tb/tb_slow_multiplication.sv
// Directed bench for the WIDTH=6 pipelined multiplier: streamed vector table
// plus hand-written hold, enable-stall and asynchronous-reset sequences.
module tb_slow_multiplication;

    localparam int W  = 6;
    localparam int NV = 12;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [W-1:0]    in_1;
    logic [W-1:0]    in_2;
    logic [2*W-1:0]  out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs [NV];

    slow_multiplication #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .in_1   (in_1),
        .in_2   (in_2),
        .out    (out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    function automatic logic arrays_nonzero();
        logic any = 1'b0;
        for (int i = 0; i < W - 1; i++) begin
            any = any | (|dut.in_1_shift[i]) | (|dut.in_2_shift[i]) | (|dut.tmp_result[i]);
        end
        return any;
    endfunction

    initial begin
        vecs[0]  = '{6'd1,  6'd10, 12'd10};
        vecs[1]  = '{6'd10, 6'd12, 12'd120};
        vecs[2]  = '{6'd60, 6'd40, 12'd2400};
        vecs[3]  = '{6'd63, 6'd63, 12'd3969};
        vecs[4]  = '{6'd0,  6'd17, 12'd0};
        vecs[5]  = '{6'd5,  6'd1,  12'd5};
        vecs[6]  = '{6'd7,  6'd9,  12'd63};
        vecs[7]  = '{6'd0,  6'd63, 12'd0};
        vecs[8]  = '{6'd63, 6'd0,  12'd0};
        vecs[9]  = '{6'd1,  6'd1,  12'd1};
        vecs[10] = '{6'd2,  6'd32, 12'd64};
        vecs[11] = '{6'd45, 6'd3,  12'd135};

        reset  = 1'b1;
        enable = 1'b1;
        in_1   = '0;
        in_2   = '0;
        #1;
        check("reset_out", out, 0);
        check("reset_arrays", arrays_nonzero(), 0);
        @(negedge clk);
        tick();
        reset = 1'b0;

        // Held operands: zero until the pipeline fills, then constant product.
        in_1 = 6'd1;
        in_2 = 6'd10;
        repeat (5) tick();
        check("hold_before_latency", out, 0);
        tick();
        check("hold_at_latency", out, 10);
        repeat (3) tick();
        check("hold_stays", out, 10);

        // Back-to-back stream: result k appears 6 clocks after operand k.
        for (int c = 0; c < NV + W; c++) begin
            if (c >= W) begin
                check($sformatf("stream[%0d] %0d*%0d", c - W, vecs[c-W].a, vecs[c-W].b),
                      out, vecs[c-W].p);
            end
            if (c < NV) begin
                in_1 = vecs[c].a;
                in_2 = vecs[c].b;
            end
            tick();
        end

        // Stall: fill with 2*3, start 7*9, freeze for 5 clocks with junk inputs.
        in_1 = 6'd2;
        in_2 = 6'd3;
        repeat (W) tick();
        check("stall_prefill", out, 6);
        in_1 = 6'd7;
        in_2 = 6'd9;
        repeat (3) tick();
        enable = 1'b0;
        in_1 = 6'd63;
        in_2 = 6'd63;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall_frozen[%0d]", i), out, 6);
        end
        enable = 1'b1;
        in_1 = 6'd0;
        in_2 = 6'd0;
        repeat (2) tick();
        check("stall_old_result", out, 6);
        tick();
        check("stall_resume_63", out, 63);
        repeat (2) tick();
        check("stall_second_63", out, 63);
        tick();
        check("stall_ignored_ops", out, 0);

        // Asynchronous reset between edges with a full pipeline.
        in_1 = 6'd60;
        in_2 = 6'd40;
        repeat (W + 2) tick();
        check("pre_reset_2400", out, 2400);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_out", out, 0);
        check("async_reset_arrays", arrays_nonzero(), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) tick();
        check("post_reset_zero", out, 0);
        tick();
        check("post_reset_2400", out, 2400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
